// File: rtl/preif_pc_gen_pkg.sv
// Shared CPU definitions: pre-IF FSM state encoding, redirect record and reset PC.
`ifndef RESET_PC
`define RESET_PC 32'hBFC0_0000
`endif

package CPU_Defines;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_STALL
  } preif_state_t;

  typedef struct packed {
    logic        valid;
    logic        is_exc;
    logic [31:0] target;
  } redirect_t;

  localparam logic [31:0] PREIF_RESET_PC = `RESET_PC;

endpackage

// File: rtl/preif_pc_gen_if.sv
// Instruction-bus address handshake between the pre-IF stage and the I-cache.
interface preif_pc_gen_if;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_addr_ok;

  modport master (output ibus_req, output ibus_addr, input ibus_addr_ok);
  modport slave  (input ibus_req, input ibus_addr, output ibus_addr_ok);
endinterface

// File: rtl/preif_pc_gen_redirect_buf.sv
// Pending-redirect buffer: holds a redirect that could not be applied and picks the winning redirect.
module preif_redirect_buf
  import CPU_Defines::*;
(
  input  logic      clk,
  input  logic      rst,
  input  redirect_t exc,
  input  redirect_t br,
  input  logic      load,
  output redirect_t pend,
  output redirect_t sel
);

  // An exception replaces anything buffered; a branch never displaces a buffered exception.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else if (load) begin
      pend <= '0;
    end else if (exc.valid) begin
      pend <= '{valid: 1'b1, is_exc: 1'b1, target: exc.target};
    end else if (br.valid && !(pend.valid && pend.is_exc)) begin
      pend <= '{valid: 1'b1, is_exc: 1'b0, target: br.target};
    end
  end

  always_comb begin
    sel = '0;
    if (exc.valid) begin
      sel = exc;
    end else if (pend.valid) begin
      sel = pend;
    end else if (br.valid) begin
      sel = br;
    end
  end

endmodule

// File: rtl/preif_pc_gen.sv
// Pre-IF stage: fetch PC register, next-PC selection and ibus address handshake.
// Optional misaligned-PC detection is enabled by defining PREIF_ALIGN_CHECK_EN.
module preif_pc_gen
  import CPU_Defines::*;
#(
  parameter logic [31:0] RESET_PC = `RESET_PC,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PREIF_Wr,
  input  logic                  EXC_Redirect,
  input  logic [31:0]           EXC_Target,
  input  logic                  BR_Redirect,
  input  logic [31:0]           BR_Target,
  preif_pc_gen_if.master        ibus,
  output logic [31:0]           PREIF_PC,
  output logic                  PREIF_Kill,
  output logic                  PREIF_AdEL
);

  preif_state_t state, state_nxt;
  logic [31:0]  pc_q, next_pc;
  logic         misal, accept, load;
  redirect_t    exc_in, br_in, pend, sel;

`ifdef PREIF_ALIGN_CHECK_EN
  assign misal      = (state != S_IDLE) && (|pc_q[1:0]);
  assign PREIF_AdEL = misal;
`else
  assign misal      = 1'b0;
  assign PREIF_AdEL = 1'b0;
`endif

  // A misaligned PC is never sent, so it is treated as accepted to let the stage move on.
  assign accept = (state == S_REQ) && (ibus.ibus_addr_ok || misal);
  assign load   = PREIF_Wr && (accept || (state == S_STALL));

  assign exc_in = '{valid: EXC_Redirect, is_exc: 1'b1, target: EXC_Target};
  assign br_in  = '{valid: BR_Redirect,  is_exc: 1'b0, target: BR_Target};

  preif_redirect_buf u_redirect_buf (
    .clk  (clk),
    .rst  (rst),
    .exc  (exc_in),
    .br   (br_in),
    .load (load),
    .pend (pend),
    .sel  (sel)
  );

  assign next_pc = sel.valid ? sel.target : (pc_q + 32'(PC_STEP));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      pc_q  <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (load) begin
        pc_q <= next_pc;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  state_nxt = S_REQ;
      S_REQ:   if (accept && !PREIF_Wr) state_nxt = S_STALL;
      S_STALL: if (PREIF_Wr) state_nxt = S_REQ;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign ibus.ibus_req  = (state == S_REQ) && !misal;
  assign ibus.ibus_addr = pc_q;
  assign PREIF_PC       = pc_q;
  assign PREIF_Kill     = accept && (pend.valid || EXC_Redirect || BR_Redirect);

endmodule
